// File: rtl/seq_pkg.sv
// seq_pkg: shared types and defaults for the seq_gen serial pattern transmitter.
// Optional feature macro used by seq_gen: SEQ_GEN_GAP_EN (one idle cycle between passes).
package seq_pkg;

  // Default geometry of the transmitter
  localparam int DEF_WIDTH = 8;
  localparam int DEF_REP_W = 4;
  localparam int LEN_W     = $clog2(DEF_WIDTH) + 1;

  // Controller states; GAP is only reachable when SEQ_GEN_GAP_EN is defined
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_gen_state_t;

  // Commands from the controller to the pattern register
  typedef enum logic [2:0] {
    SR_HOLD   = 3'd0,  // keep everything
    SR_LOAD   = 3'd1,  // capture pattern/length, present first bit
    SR_STEP   = 3'd2,  // move to the next lower bit
    SR_RELOAD = 3'd3,  // restart the pattern, present its first bit now
    SR_REARM  = 3'd4,  // restart the pattern, but drive 0 this cycle (gap)
    SR_SHOW   = 3'd5,  // present the bit at the current index
    SR_BLANK  = 3'd6   // drive 0
  } shreg_cmd_t;

endpackage

// File: rtl/seq_gen_shreg.sv
// seq_gen_shreg: stored pattern, bit index and registered serial output bit.
// The pattern is captured once per load and never modified, so every pass
// replays identical data.
module seq_gen_shreg
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  shreg_cmd_t             cmd,
  input  logic [WIDTH-1:0]       load_data,
  input  logic [$clog2(WIDTH):0] load_len,   // already clamped to WIDTH
  output logic                   x,
  output logic                   last        // index points at bit 0
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W:0]   LEN_ONE = 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  logic [WIDTH-1:0] pattern_reg;
  logic [IDX_W:0]   len_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             x_reg;

  logic [IDX_W-1:0] load_top;
  logic [IDX_W-1:0] len_top;
  logic [IDX_W-1:0] idx_dec;

  // Index of the first (most significant) bit of the active window and the next index
  always_comb begin
    load_top = IDX_W'(load_len - LEN_ONE);
    len_top  = IDX_W'(len_reg - LEN_ONE);
    idx_dec  = idx_reg - IDX_ONE;
  end

  // Pattern storage and serial bit selection, one command per cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_reg <= '0;
      len_reg     <= '0;
      idx_reg     <= '0;
      x_reg       <= 1'b0;
    end else begin
      case (cmd)
        SR_LOAD: begin
          pattern_reg <= load_data;
          len_reg     <= load_len;
          if (load_len != '0) begin
            idx_reg <= load_top;
            x_reg   <= load_data[load_top];
          end else begin
            idx_reg <= '0;
            x_reg   <= 1'b0;
          end
        end
        SR_STEP: begin
          idx_reg <= idx_dec;
          x_reg   <= pattern_reg[idx_dec];
        end
        SR_RELOAD: begin
          idx_reg <= len_top;
          x_reg   <= pattern_reg[len_top];
        end
        SR_REARM: begin
          idx_reg <= len_top;
          x_reg   <= 1'b0;
        end
        SR_SHOW:  x_reg <= pattern_reg[idx_reg];
        SR_BLANK: x_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign x    = x_reg;
  assign last = (idx_reg == '0);

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial test-pattern transmitter with valid/ready load port.
// Sends load_len bits of load_data MSB-of-window first, load_rep+1 times,
// then pulses done for one cycle. Define SEQ_GEN_GAP_EN to insert one idle
// cycle (x_valid=0) between consecutive passes.
module seq_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int REP_W = DEF_REP_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WIDTH-1:0]       load_data,
  input  logic [$clog2(WIDTH):0] load_len,
  input  logic [REP_W-1:0]       load_rep,
  output logic                   x,
  output logic                   x_valid,
  output logic                   busy,
  output logic                   done
);

  localparam int LEN_BITS = $clog2(WIDTH) + 1;
  localparam logic [LEN_BITS-1:0] LEN_MAX = LEN_BITS'(WIDTH);
  localparam logic [REP_W-1:0]    REP_ONE = 1;

  seq_gen_state_t      state_reg;
  logic [REP_W-1:0]    rep_reg;
  logic                load_ready_reg;
  logic                x_valid_reg;
  logic                busy_reg;
  logic                done_reg;

  logic [LEN_BITS-1:0] eff_len;
  shreg_cmd_t          cmd;
  logic                last_bit;

  // Over-long requests are clamped to the register width
  always_comb begin
    eff_len = (load_len > LEN_MAX) ? LEN_MAX : load_len;
  end

  // Pattern register command for this cycle, derived from the current state
  always_comb begin
    cmd = SR_HOLD;
    case (state_reg)
      IDLE: if (load_valid) cmd = SR_LOAD;
      SHIFT: begin
        if (!last_bit) begin
          cmd = SR_STEP;
        end else if (rep_reg != '0) begin
`ifdef SEQ_GEN_GAP_EN
          cmd = SR_REARM;
`else
          cmd = SR_RELOAD;
`endif
        end else begin
          cmd = SR_BLANK;
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: cmd = SR_SHOW;
`endif
      default: cmd = SR_HOLD;
    endcase
  end

  seq_gen_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cmd),
    .load_data (load_data),
    .load_len  (eff_len),
    .x         (x),
    .last      (last_bit)
  );

  // Controller FSM with repeat counter and registered handshake/status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      rep_reg        <= '0;
      load_ready_reg <= 1'b1;
      x_valid_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load_valid) begin
            rep_reg        <= load_rep;
            load_ready_reg <= 1'b0;
            busy_reg       <= 1'b1;
            if (eff_len != '0) begin
              state_reg   <= SHIFT;
              x_valid_reg <= 1'b1;
            end else begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (last_bit) begin
            if (rep_reg != '0) begin
              rep_reg <= rep_reg - REP_ONE;
`ifdef SEQ_GEN_GAP_EN
              state_reg   <= GAP;
              x_valid_reg <= 1'b0;
`endif
            end else begin
              state_reg   <= DONE;
              x_valid_reg <= 1'b0;
              done_reg    <= 1'b1;
            end
          end
        end
`ifdef SEQ_GEN_GAP_EN
        GAP: begin
          state_reg   <= SHIFT;
          x_valid_reg <= 1'b1;
        end
`endif
        DONE: begin
          state_reg      <= IDLE;
          done_reg       <= 1'b0;
          busy_reg       <= 1'b0;
          load_ready_reg <= 1'b1;
        end
        default: begin
          state_reg      <= IDLE;
          x_valid_reg    <= 1'b0;
          done_reg       <= 1'b0;
          busy_reg       <= 1'b0;
          load_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign load_ready = load_ready_reg;
  assign x_valid    = x_valid_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: directed self-checking bench for seq_gen (WIDTH=8, REP_W=4).
// Honours SEQ_GEN_GAP_EN when the design is built with it.
`timescale 1ns/1ps
module tb_seq_gen;

  logic       clk;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic [3:0] load_len;
  logic [3:0] load_rep;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  int tests_run;
  int tests_failed;

  seq_gen dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .load_rep   (load_rep),
    .x          (x),
    .x_valid    (x_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one pattern and follow it to the end; exp holds the n expected bits
  // (first bit at exp[n-1]), l is the pattern length used to place gap cycles.
  task automatic run(input string tag, input logic [7:0] data, input logic [3:0] len,
                     input logic [3:0] rep, input logic [63:0] exp, input int n, input int l);
    load_valid = 1'b1;
    load_data  = data;
    load_len   = len;
    load_rep   = rep;
    tick();
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_len   = 4'd0;
    load_rep   = 4'd0;
    for (int k = 0; k < n; k++) begin
`ifdef SEQ_GEN_GAP_EN
      if (k > 0 && (k % l) == 0) begin
        check({tag, " gap x_valid"}, 32'(x_valid), 32'd0);
        check({tag, " gap x"}, 32'(x), 32'd0);
        check({tag, " gap busy"}, 32'(busy), 32'd1);
        tick();
      end
`else
      if (l == 0) check({tag, " len arg"}, 32'(l), 32'd1);
`endif
      check($sformatf("%s bit%0d x", tag, k), 32'(x), 32'(exp[n-1-k]));
      check($sformatf("%s bit%0d x_valid", tag, k), 32'(x_valid), 32'd1);
      check($sformatf("%s bit%0d ready", tag, k), 32'(load_ready), 32'd0);
      tick();
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " done x_valid"}, 32'(x_valid), 32'd0);
    check({tag, " done x"}, 32'(x), 32'd0);
    check({tag, " done ready"}, 32'(load_ready), 32'd0);
    tick();
    check({tag, " post done"}, 32'(done), 32'd0);
    check({tag, " post ready"}, 32'(load_ready), 32'd1);
    check({tag, " post busy"}, 32'(busy), 32'd0);
    $display("[TB] txn %s: data=%02h len=%0d rep=%0d bits=%0d", tag, data, len, rep, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_len   = 4'd0;
    load_rep   = 4'd0;
    tick();
    tick();
    check("rst ready", 32'(load_ready), 32'd1);
    check("rst x", 32'(x), 32'd0);
    check("rst x_valid", 32'(x_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    rst = 1'b1;
    tick();
    check("idle ready", 32'(load_ready), 32'd1);
    $display("[TB] txn reset: complete");

    run("basic", 8'b0000_1101, 4'd4, 4'd0, 64'b1101, 4, 4);
    run("rep1", 8'b0000_1101, 4'd4, 4'd1, 64'b1101_1101, 8, 4);
    run("len0", 8'hFF, 4'd0, 4'd3, 64'd0, 0, 1);
    run("len9", 8'hA5, 4'd9, 4'd0, 64'b1010_0101, 8, 8);
    run("repmax", 8'h02, 4'd2, 4'd15, 64'hAAAA_AAAA, 32, 2);

    // Load held high during a pattern: ignored until the cycle after done
    load_valid = 1'b1;
    load_data  = 8'b0000_1101;
    load_len   = 4'd4;
    load_rep   = 4'd0;
    tick();
    load_data = 8'h07;
    load_len  = 4'd3;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] hx;
      hx = 4'b1101;
      check($sformatf("hold bit%0d x", k), 32'(x), 32'(hx[3-k]));
      check($sformatf("hold bit%0d ready", k), 32'(load_ready), 32'd0);
      tick();
    end
    check("hold done", 32'(done), 32'd1);
    check("hold done ready", 32'(load_ready), 32'd0);
    tick();
    check("hold idle ready", 32'(load_ready), 32'd1);
    check("hold idle x_valid", 32'(x_valid), 32'd0);
    check("hold idle done", 32'(done), 32'd0);
    tick();
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold2 bit%0d x", k), 32'(x), 32'd1);
      check($sformatf("hold2 bit%0d x_valid", k), 32'(x_valid), 32'd1);
      tick();
    end
    check("hold2 done", 32'(done), 32'd1);
    tick();
    check("hold2 ready", 32'(load_ready), 32'd1);
    $display("[TB] txn hold: second pattern accepted after done");

    // Reset dropped during the third bit of a 4-bit pattern
    load_valid = 1'b1;
    load_data  = 8'h0F;
    load_len   = 4'd4;
    load_rep   = 4'd0;
    tick();
    load_valid = 1'b0;
    check("rstmid bit0 x", 32'(x), 32'd1);
    tick();
    tick();
    check("rstmid bit2 x", 32'(x), 32'd1);
    check("rstmid bit2 x_valid", 32'(x_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid x", 32'(x), 32'd0);
    check("rstmid x_valid", 32'(x_valid), 32'd0);
    check("rstmid busy", 32'(busy), 32'd0);
    check("rstmid done", 32'(done), 32'd0);
    check("rstmid ready", 32'(load_ready), 32'd1);
    tick();
    check("rstmid hold done", 32'(done), 32'd0);
    tick();
    rst = 1'b1;
    check("rstmid rel done", 32'(done), 32'd0);
    tick();
    check("rstmid rel ready", 32'(load_ready), 32'd1);
    check("rstmid rel busy", 32'(busy), 32'd0);
    check("rstmid rel done2", 32'(done), 32'd0);
    $display("[TB] txn reset-mid: pattern discarded");

    run("after_rst", 8'b0000_1101, 4'd4, 4'd0, 64'b1101, 4, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Serial test-pattern transmitter: accepts a parallel bit pattern through a valid/ready load port and emits it one bit per clock on a serial output, MSB of the active window first, optionally repeated. It is the source end of the serial bit stream consumed by the `seq_det` sequence detector, whose `x` input it drives. It replaces hand-written `#10 x=...` stimulus in benches and serves as an on-chip pattern source.

## Interface
- `WIDTH`, 8: maximum pattern length in bits (≥2).
- `REP_W`, 4: width of the repeat-count field.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset; asserting 0 resets all state immediately.
- `load_valid`  in  1  pattern offered.
- `load_ready`  out  1  block can accept a pattern.
- `load_data`  in  WIDTH  pattern; bit `load_len-1` is sent first, bit 0 last.
- `load_len`  in  $clog2(WIDTH)+1  number of bits to send.
- `load_rep`  in  REP_W  extra repetitions; total passes = `load_rep`+1.
- `x`  out  1  serial bit; forced 0 whenever `x_valid`=0.
- `x_valid`  out  1  `x` carries a pattern bit this cycle.
- `busy`  out  1  pattern in progress (not IDLE).
- `done`  out  1  one-cycle pulse after the last bit of the last pass.

## Operation
- States: IDLE, SHIFT, GAP (present only with the macro), DONE.
- IDLE: `load_ready`=1. A load is accepted when `load_valid`&&`load_ready` at a rising edge; the block captures data, the effective length and rep. Next state: SHIFT, or DONE if the effective length is 0.
- Length rule: effective length = min(`load_len`, WIDTH); `load_len`=0 sends nothing and produces only the `done` pulse.
- SHIFT: each cycle drive `x`=pattern[bit_idx], `x_valid`=1, decrement bit_idx. After bit 0:
  - If passes remain: decrement the rep counter, reload bit_idx=len-1 from the stored pattern, and go to SHIFT (back-to-back) or GAP.
  - Otherwise: go to DONE.
- DONE: `done`=1, `x_valid`=0 for exactly one cycle, then IDLE.
- `load_ready`=0 in SHIFT, GAP and DONE; `load_valid` is ignored there, and `load_data` is not sampled.
- The stored pattern is held unchanged for all passes. The input ports may change after acceptance with no effect.
- All outputs are registered. No combinational path from inputs to outputs.

## Timing
- Reset values: `load_ready`=1, `x`=0, `x_valid`=0, `busy`=0, `done`=0, state IDLE, counters 0.
- Latency: the first bit appears on `x` in the cycle after the accepting edge.
- A pattern of length L with R repeats without the gap occupies L·(R+1) consecutive `x_valid` cycles, followed by 1 `done` cycle. A new load is accepted at the earliest one cycle after `done`.
- Reset asserted mid-pattern: outputs go to their reset values asynchronously. The partial pattern is discarded and `done` is not pulsed. After release, the block is in IDLE with `load_ready`=1.
- The rep counter is at full scale when `load_rep`=2^REP_W−1: 2^REP_W passes, with no overflow or wrap.

## Configuration
- `SEQ_GEN_GAP_EN` defined: a one-cycle GAP state is inserted between passes. During GAP, `x`=0, `x_valid`=0 and `busy`=1. No GAP follows the final pass. Total duration is L·(R+1)+R cycles, plus 1 `done` cycle.
- Not defined: the GAP state does not exist and passes are back-to-back.

## Structure
- Package `seq_pkg`:
  - state enum `seq_gen_state_t` {IDLE, SHIFT, GAP, DONE};
  - default `WIDTH`/`REP_W` localparams;
  - `LEN_W` = $clog2(WIDTH)+1.
- One natural sub-module: `seq_gen_shreg`, the pattern register plus bit index and serial mux. The FSM and repeat counter stay in `seq_gen`.

## Test plan
- Load `load_data`=8'b0000_1101, `load_len`=4, `load_rep`=0 → `x` = 1,1,0,1 with `x_valid`=1 on cycles 1–4 after accept; `done`=1 on cycle 5. When chained into `seq_det`, `z` asserts on the final 1.
- Same pattern with `load_rep`=1 → `x` = 1101 1101 over 8 consecutive cycles, then `done`. With `SEQ_GEN_GAP_EN` defined: 1101, one cycle with `x_valid`=0, then 1101.
- `load_len`=0 → no `x_valid` cycles; `done` pulses the cycle after accept; `load_ready`=1 the cycle after that.
- `load_len`=9 with WIDTH=8 and `load_data`=8'hA5 → 8 bits 1,0,1,0,0,1,0,1, then `done`.
- Hold `load_valid`=1 with a different pattern during SHIFT → `load_ready`=0 and output unaffected; the second pattern is accepted only in the cycle after `done`.
- Drop `rst` to 0 on the third bit of a 4-bit pattern → `x`, `x_valid` and `busy` go to 0 immediately and no `done` pulse occurs. After release `load_ready`=1, and a fresh load behaves as in the first scenario.
